// File: rtl/sa_pkg.sv
// Shared types and width helpers for the systolic-array partial-sum path.
// Contents:
//   acc_state_t - accumulator buffer FSM states
//   sext        - sign-extend the low w bits of a 64-bit container
//   sat_add     - add two sign-extended values and clamp to a signed w-bit range
//   sat_clip    - flags when sat_add had to clamp
// Callers keep w below 64 so that the 64-bit sum cannot overflow.
package sa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } acc_state_t;

    // Replicate bit w-1 into every bit above it.
    function automatic logic [63:0] sext(input logic [63:0] x, input int unsigned w);
        logic [63:0] m;
        m = ~64'd0 << w;
        return x[6'(w - 1)] ? (x | m) : (x & ~m);
    endfunction

    // Signed add clamped to [-2^(w-1), 2^(w-1)-1].
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = $signed(a + b);
        hi = $signed((64'd1 << (w - 1)) - 64'd1);
        lo = ~hi;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

    // True when sat_add would clamp for the same operands.
    function automatic logic sat_clip(input logic [63:0] a, input logic [63:0] b,
                                      input int unsigned w);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = $signed(a + b);
        hi = $signed((64'd1 << (w - 1)) - 64'd1);
        lo = ~hi;
        return (s > hi) || (s < lo);
    endfunction

endpackage

// File: rtl/psum_accum_buffer_acc_lane.sv
// acc_lane: one accumulator lane of the partial-sum buffer (purely combinational).
// Ports:
//   i_psum       - incoming signed partial sum
//   i_acc        - current accumulator value read from the buffer
//   i_first_tile - first reduction tile: result is the extended psum alone
//   o_result_c   - value to write back
//   o_clip_c     - (ACCUM_SAT_EN only) the add was clamped
// Macro ACCUM_SAT_EN selects saturating accumulation; otherwise the sum wraps.
module acc_lane
    import sa_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32
) (
    input  logic [PSUM_WIDTH-1:0] i_psum,
    input  logic [ACC_WIDTH-1:0]  i_acc,
    input  logic                  i_first_tile,
    output logic [ACC_WIDTH-1:0]  o_result_c
`ifdef ACCUM_SAT_EN
    ,
    output logic                  o_clip_c
`endif
);

    logic [ACC_WIDTH-1:0] w_psum_ext;

    assign w_psum_ext = ACC_WIDTH'(sext(64'(i_psum), PSUM_WIDTH));

`ifdef ACCUM_SAT_EN
    logic [63:0] w_acc_64;
    logic [63:0] w_psum_64;

    assign w_acc_64   = sext(64'(i_acc), ACC_WIDTH);
    assign w_psum_64  = sext(64'(i_psum), PSUM_WIDTH);
    assign o_result_c = i_first_tile ? w_psum_ext
                                     : ACC_WIDTH'(sat_add(w_acc_64, w_psum_64, ACC_WIDTH));
    assign o_clip_c   = !i_first_tile && sat_clip(w_acc_64, w_psum_64, ACC_WIDTH);
`else
    assign o_result_c = i_first_tile ? w_psum_ext : (i_acc + w_psum_ext);
`endif

endmodule

// File: rtl/psum_accum_buffer.sv
// psum_accum_buffer: accumulates ARRAY_HEIGHT-lane partial-sum vectors across
// cfg_tiles reduction tiles into a cfg_rows-deep buffer, then drains the
// finished vectors over a valid/ready stream.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   start, cfg_rows, cfg_tiles - job launch and its (clamped) geometry
//   busy                      - job in progress
//   psum_valid, packed_psum_in - incoming vectors, lane i at [i*PSUM_WIDTH +: PSUM_WIDTH]
//   out_valid, out_ready, packed_out, out_last - drain stream, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   err_drop                  - sticky: a vector arrived outside accumulation
//   sat_flag                  - (ACCUM_SAT_EN only) sticky: a lane clipped this job
// Macro ACCUM_SAT_EN enables saturating accumulation and the sat_flag port.
module psum_accum_buffer
    import sa_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH    = 32,
    parameter int unsigned ARRAY_HEIGHT = 4,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned TILE_W       = 8,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [ADDR_W:0]                  cfg_rows,
    input  logic [TILE_W-1:0]                cfg_tiles,
    output logic                             busy,
    input  logic                             psum_valid,
    input  logic [PSUM_WIDTH*ARRAY_HEIGHT-1:0] packed_psum_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ACC_WIDTH*ARRAY_HEIGHT-1:0] packed_out,
    output logic                             out_last,
    output logic                             err_drop
`ifdef ACCUM_SAT_EN
    ,
    output logic                             sat_flag
`endif
);

    localparam int unsigned VEC_W = ACC_WIDTH * ARRAY_HEIGHT;

    acc_state_t          r_state;
    logic                r_busy;
    logic                r_out_valid;
    logic                r_out_last;
    logic [VEC_W-1:0]    r_packed_out;
    logic                r_err_drop;
    logic [ADDR_W-1:0]   r_rows_m1;
    logic [TILE_W-1:0]   r_tiles_m1;
    logic [ADDR_W-1:0]   r_row;
    logic [TILE_W-1:0]   r_tile;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [VEC_W-1:0]    r_mem [DEPTH];

    logic [ADDR_W-1:0]   w_rows_m1;
    logic [TILE_W-1:0]   w_tiles_m1;
    logic [ADDR_W-1:0]   w_rd_next;
    logic [VEC_W-1:0]    w_rd_vec;
    logic [VEC_W-1:0]    w_result;
    logic                w_first_tile;
    logic                w_wr_en;

    // Clamp the requested geometry to 1..DEPTH rows and at least one tile.
    always_comb begin
        w_rows_m1 = '0;
        if (cfg_rows > (ADDR_W + 1)'(DEPTH)) begin
            w_rows_m1 = ADDR_W'(DEPTH - 1);
        end else if (cfg_rows != '0) begin
            w_rows_m1 = ADDR_W'(cfg_rows - (ADDR_W + 1)'(1));
        end
    end

    assign w_tiles_m1   = (cfg_tiles == '0) ? '0 : (cfg_tiles - TILE_W'(1));
    assign w_rd_next    = r_rd_ptr + ADDR_W'(1);
    assign w_rd_vec     = r_mem[r_row];
    assign w_first_tile = (r_tile == '0);
    assign w_wr_en      = (r_state == ACCUM) && psum_valid;

`ifdef ACCUM_SAT_EN
    logic [ARRAY_HEIGHT-1:0] w_clip;
    logic                    r_sat_flag;
    assign sat_flag = r_sat_flag;
`endif

    // Lane datapaths operate on the row currently being accumulated.
    for (genvar g = 0; g < ARRAY_HEIGHT; g++) begin : g_lane
        acc_lane #(
            .PSUM_WIDTH (PSUM_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .i_psum       (packed_psum_in[g*PSUM_WIDTH +: PSUM_WIDTH]),
            .i_acc        (w_rd_vec[g*ACC_WIDTH +: ACC_WIDTH]),
            .i_first_tile (w_first_tile),
            .o_result_c   (w_result[g*ACC_WIDTH +: ACC_WIDTH])
`ifdef ACCUM_SAT_EN
            ,
            .o_clip_c     (w_clip[g])
`endif
        );
    end

    // Buffer storage: not reset, tile 0 overwrites every live row.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_row] <= w_result;
        end
    end

    // Job control FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_packed_out <= '0;
            r_err_drop   <= 1'b0;
            r_rows_m1    <= '0;
            r_tiles_m1   <= '0;
            r_row        <= '0;
            r_tile       <= '0;
            r_rd_ptr     <= '0;
`ifdef ACCUM_SAT_EN
            r_sat_flag   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ACCUM;
                        r_busy     <= 1'b1;
                        r_rows_m1  <= w_rows_m1;
                        r_tiles_m1 <= w_tiles_m1;
                        r_row      <= '0;
                        r_tile     <= '0;
                        // Clear, but a vector arriving with start is still a drop.
                        r_err_drop <= psum_valid;
`ifdef ACCUM_SAT_EN
                        r_sat_flag <= 1'b0;
`endif
                    end else if (psum_valid) begin
                        r_err_drop <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (psum_valid) begin
`ifdef ACCUM_SAT_EN
                        if (|w_clip) begin
                            r_sat_flag <= 1'b1;
                        end
`endif
                        if (r_row == r_rows_m1) begin
                            r_row <= '0;
                            if (r_tile == r_tiles_m1) begin
                                r_state     <= DRAIN;
                                r_out_valid <= 1'b1;
                                r_rd_ptr    <= '0;
                                r_out_last  <= (r_rows_m1 == '0);
                                // Single-row job: row 0 is being written this edge.
                                r_packed_out <= (r_rows_m1 == '0) ? w_result : r_mem[0];
                            end else begin
                                r_tile <= r_tile + TILE_W'(1);
                            end
                        end else begin
                            r_row <= r_row + ADDR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (psum_valid) begin
                        r_err_drop <= 1'b1;
                    end
                    if (r_out_valid && out_ready) begin
                        if (r_out_last) begin
                            r_state     <= IDLE;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_rd_ptr     <= w_rd_next;
                            r_packed_out <= r_mem[w_rd_next];
                            r_out_last   <= (w_rd_next == r_rows_m1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign packed_out = r_packed_out;
    assign err_drop   = r_err_drop;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboard bench for psum_accum_buffer: jobs are modelled as plain per-row
// sums, expected drain beats are queued at launch, and a monitor pops and
// compares every accepted beat. A second 16-bit-accumulator instance checks
// the overflow behaviour (wrap, or clamp with ACCUM_SAT_EN).
module tb_psum_accum_buffer;

    localparam int PW = 16;
    localparam int AW = 32;
    localparam int H  = 4;
    localparam int D  = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     cfg_rows;
    logic [7:0]     cfg_tiles;
    logic           busy;
    logic           psum_valid;
    logic [PW*H-1:0] packed_psum_in;
    logic           out_valid;
    logic           out_ready;
    logic [AW*H-1:0] packed_out;
    logic           out_last;
    logic           err_drop;

    logic           s_start;
    logic [3:0]     s_cfg_rows;
    logic [7:0]     s_cfg_tiles;
    logic           s_busy;
    logic           s_psum_valid;
    logic [PW*H-1:0] s_psum;
    logic           s_out_valid;
    logic           s_out_ready;
    logic [16*H-1:0] s_packed_out;
    logic           s_out_last;
    logic           s_err_drop;
`ifdef ACCUM_SAT_EN
    logic           sat_flag;
    logic           s_sat_flag;
`endif

    psum_accum_buffer #(
        .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .ARRAY_HEIGHT(H), .DEPTH(D), .TILE_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles),
        .busy(busy), .psum_valid(psum_valid), .packed_psum_in(packed_psum_in),
        .out_valid(out_valid), .out_ready(out_ready), .packed_out(packed_out),
        .out_last(out_last), .err_drop(err_drop)
`ifdef ACCUM_SAT_EN
        , .sat_flag(sat_flag)
`endif
    );

    psum_accum_buffer #(
        .PSUM_WIDTH(PW), .ACC_WIDTH(16), .ARRAY_HEIGHT(H), .DEPTH(D), .TILE_W(8)
    ) u_dut16 (
        .clk(clk), .rst(rst), .start(s_start), .cfg_rows(s_cfg_rows), .cfg_tiles(s_cfg_tiles),
        .busy(s_busy), .psum_valid(s_psum_valid), .packed_psum_in(s_psum),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .packed_out(s_packed_out),
        .out_last(s_out_last), .err_drop(s_err_drop)
`ifdef ACCUM_SAT_EN
        , .sat_flag(s_sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW*H-1:0] data;
        logic            last;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    int          pidx = 0;
    bit          rpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit          hold_valid = 1'b0;
    logic [AW*H-1:0] hold_data;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer ready: always, random, or the 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready = rpat[pidx];
                pidx = (pidx + 1) % 4;
            end
        endcase
    end

    // Monitor: every accepted beat is compared with the next queued expectation;
    // a stalled beat must be presented unchanged on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_data", packed_out, hold_data);
            end
            if (out_valid && out_ready) begin
                hold_valid = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat actual=%0h required=no_beat", packed_out);
                end else begin
                    e = exp_q.pop_front();
                    check("drain_data", packed_out, e.data);
                    check("drain_last", 128'(out_last), 128'(e.last));
                end
            end else if (out_valid) begin
                hold_valid = 1'b1;
                hold_data  = packed_out;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    // Lane value for vector (tile t, row r, lane l) of a given stimulus kind.
    function automatic int psum_val(input int kind, input int t, input int r, input int l);
        case (kind)
            1: return r * 4 + l + 1;
            2: return 16;
            3: if (l == 0) return (t == 0) ? -5 : 2;
               else return int'($urandom_range(0, 65535)) - 32768;
            default: return int'($urandom_range(0, 65535)) - 32768;
        endcase
    endfunction

    task automatic run_job(input int rows_cfg, input int tiles_cfg, input int kind,
                           input int rmode, input bit junk_start, input bit mid_start,
                           input bit drain_poke);
        int     nrows;
        int     ntiles;
        int     pv[$];
        longint acc[D][H];
        exp_t   e;
        int     n;
        int     idx;
        bit     poked;
        nrows  = (rows_cfg == 0) ? 1 : (rows_cfg > D) ? D : rows_cfg;
        ntiles = (tiles_cfg == 0) ? 1 : tiles_cfg;
        // Reference: each row is the sum over tiles of its sign-extended vectors.
        for (int t = 0; t < ntiles; t++) begin
            for (int r = 0; r < nrows; r++) begin
                for (int l = 0; l < H; l++) begin
                    int v;
                    v = psum_val(kind, t, r, l);
                    pv.push_back(v);
                    acc[r][l] = (t == 0) ? longint'(v) : acc[r][l] + longint'(v);
                end
            end
        end
        for (int r = 0; r < nrows; r++) begin
            for (int l = 0; l < H; l++) begin
                e.data[l*AW +: AW] = 32'(acc[r][l]);
            end
            e.last = (r == nrows - 1);
            exp_q.push_back(e);
        end
        ready_mode = rmode;
        pidx = 0;
        start     = 1'b1;
        cfg_rows  = 4'(rows_cfg);
        cfg_tiles = 8'(tiles_cfg);
        if (junk_start) begin
            psum_valid     = 1'b1;
            packed_psum_in = {$urandom, $urandom};
        end
        tick();
        start      = 1'b0;
        psum_valid = 1'b0;
        cfg_rows   = 4'($urandom);
        cfg_tiles  = 8'($urandom);
        check("busy_after_start", 128'(busy), 128'(1));
        check("err_after_start", 128'(err_drop), 128'(junk_start));
        idx = 0;
        for (int v = 0; v < nrows * ntiles; v++) begin
            while ($urandom_range(0, 3) == 0) begin
                psum_valid = 1'b0;
                tick();
            end
            if (mid_start && v == 1) begin
                start     = 1'b1;
                cfg_rows  = 4'd1;
                cfg_tiles = 8'd1;
                tick();
                start = 1'b0;
            end
            psum_valid = 1'b1;
            for (int l = 0; l < H; l++) begin
                packed_psum_in[l*PW +: PW] = 16'(pv[idx]);
                idx++;
            end
            tick();
        end
        psum_valid     = 1'b0;
        packed_psum_in = {$urandom, $urandom};
        n = 0;
        poked = 1'b0;
        while (busy && n < 500) begin
            if (drain_poke && !poked && out_valid) begin
                psum_valid = 1'b1;
                poked = 1'b1;
            end else begin
                psum_valid = 1'b0;
            end
            tick();
            n++;
        end
        psum_valid = 1'b0;
        check("job_done_in_time", 128'(n < 500), 128'(1));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_out_valid", 128'(out_valid), 128'(0));
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        check("err_drop_end", 128'(err_drop), 128'(junk_start | drain_poke));
`ifdef ACCUM_SAT_EN
        check("sat_flag_clear", 128'(sat_flag), 128'(0));
`endif
        exp_q.delete();
        tick();
    endtask

    initial begin
        int     n;
        longint s16;
        logic [15:0] e16;
        rst = 1'b1;
        start = 1'b0;
        cfg_rows = '0;
        cfg_tiles = '0;
        psum_valid = 1'b0;
        packed_psum_in = '0;
        out_ready = 1'b1;
        s_start = 1'b0;
        s_cfg_rows = '0;
        s_cfg_tiles = '0;
        s_psum_valid = 1'b0;
        s_psum = '0;
        s_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_last", 128'(out_last), 128'(0));
        check("rst_packed_out", packed_out, 128'(0));
        check("rst_err_drop", 128'(err_drop), 128'(0));

        // Vector while idle is dropped and flagged.
        psum_valid = 1'b1;
        packed_psum_in = {$urandom, $urandom};
        tick();
        psum_valid = 1'b0;
        check("idle_drop_err", 128'(err_drop), 128'(1));
        check("idle_drop_busy", 128'(busy), 128'(0));

        run_job(2, 1, 1, 0, 1'b0, 1'b0, 1'b0);
        run_job(3, 3, 2, 0, 1'b0, 1'b0, 1'b0);
        run_job(1, 2, 3, 0, 1'b0, 1'b0, 1'b0);
        run_job(5, 2, 0, 2, 1'b0, 1'b0, 1'b0);
        run_job(0, 0, 0, 1, 1'b1, 1'b0, 1'b0);
        run_job(15, 3, 0, 1, 1'b0, 1'b1, 1'b1);
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(0, 9)), int'($urandom_range(0, 4)), 0, 1,
                    1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        // Abort mid-accumulation with reset.
        start = 1'b1;
        cfg_rows = 4'd4;
        cfg_tiles = 8'd2;
        psum_valid = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin
            packed_psum_in = {$urandom, $urandom};
            tick();
        end
        psum_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        check("abort_err_drop", 128'(err_drop), 128'(0));
        tick();
        run_job(4, 2, 0, 1, 1'b0, 1'b0, 1'b0);

        // 16-bit accumulator overflow: 0x7FFF + 0x0001.
        s16 = 64'sd32767 + 64'sd1;
`ifdef ACCUM_SAT_EN
        e16 = (s16 > 32767) ? 16'h7FFF : 16'(s16);
`else
        e16 = 16'(s16);
`endif
        s_start = 1'b1;
        s_cfg_rows = 4'd1;
        s_cfg_tiles = 8'd2;
        tick();
        s_start = 1'b0;
        s_psum_valid = 1'b1;
        s_psum = 64'h0000_0000_0000_7FFF;
        tick();
        s_psum = 64'h0000_0000_0000_0001;
        tick();
        s_psum_valid = 1'b0;
        n = 0;
        while (!s_out_valid && n < 20) begin
            tick();
            n++;
        end
        check("ovf_timeout", 128'(n < 20), 128'(1));
        check("ovf_lane0", 128'(s_packed_out[15:0]), 128'(e16));
        check("ovf_other_lanes", 128'(s_packed_out[63:16]), 128'(0));
        check("ovf_last", 128'(s_out_last), 128'(1));
`ifdef ACCUM_SAT_EN
        check("ovf_sat_flag", 128'(s_sat_flag), 128'(1));
`endif
        tick();
        tick();
        check("ovf_busy_end", 128'(s_busy), 128'(0));
        check("ovf_err_drop", 128'(s_err_drop), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
